// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: merges a never-stalled ALU writeback stream with a
// queued LSU load stream into one registered register-file write port.
module gpr_wb_arbiter #(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [4:0]                alu_wa,
  input  logic [31:0]               alu_wd,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [4:0]                lsu_wa,
  input  logic [31:0]               lsu_wd,
  input  logic [4:0]                rs,
  input  logic [4:0]                rt,
  output logic                      raw_hazard,
  output logic                      we,
  output logic [4:0]                wa,
  output logic [31:0]               wd,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  // Queue storage and bookkeeping
  logic [4:0]        r_q_wa [QDEPTH];
  logic [31:0]       r_q_wd [QDEPTH];
  logic [QDEPTH-1:0] r_q_valid;
  logic [QDEPTH-1:0] r_q_kill;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              r_we;
  logic [4:0]        r_wa;
  logic [31:0]       r_wd;

  logic              w_alu_req;
  logic              w_lsu_nonnull;
  logic              w_q_empty;
  logic              w_sel_head;
  logic              w_bypass;
  logic              w_push;
  logic              w_push_killed;
  logic              w_head_killed;
  logic [QDEPTH-1:0] w_kill_hit;
  logic              w_hazard;

  assign lsu_ready     = !rst && (r_count < DEPTH_C);
  assign w_alu_req     = alu_valid && (alu_wa != 5'd0);
  assign w_lsu_nonnull = lsu_valid && lsu_ready && (lsu_wa != 5'd0);
  assign w_q_empty     = (r_count == '0);
  assign w_sel_head    = !w_alu_req && !w_q_empty;
  assign w_bypass      = !w_alu_req && w_q_empty && w_lsu_nonnull;
  assign w_push        = w_lsu_nonnull && !w_bypass;
  assign w_push_killed = w_alu_req && (lsu_wa == alu_wa);
  assign w_head_killed = r_q_kill[r_rd_ptr];

  // The ALU result is younger than anything still queued for the same register.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_kill_hit = '0;
    w_hazard   = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      w_kill_hit[i] = w_alu_req && r_q_valid[i] && (r_q_wa[i] == alu_wa);
      if (r_q_valid[i] && !r_q_kill[i] &&
          (((rs != 5'd0) && (rs == r_q_wa[i])) || ((rt != 5'd0) && (rt == r_q_wa[i]))))
        w_hazard = 1'b1;
    end
    if (r_we && (((rs != 5'd0) && (rs == r_wa)) || ((rt != 5'd0) && (rt == r_wa))))
      w_hazard = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_valid <= '0;
      r_q_kill  <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_q_kill <= r_q_kill | w_kill_hit;
      if (w_sel_head) begin
        r_q_valid[r_rd_ptr] <= 1'b0;
        r_q_kill[r_rd_ptr]  <= 1'b0;
        r_rd_ptr            <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_q_valid[r_wr_ptr] <= 1'b1;
        r_q_kill[r_wr_ptr]  <= w_push_killed;
        r_wr_ptr            <= r_wr_ptr + AW'(1);
      end
      case ({w_push, w_sel_head})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: queue payload is not reset; the valid flags alone decide whether an entry means anything.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_wa[r_wr_ptr] <= lsu_wa;
      r_q_wd[r_wr_ptr] <= lsu_wd;
    end
  end

  // A killed head still spends its slot but writes nothing; wa/wd keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else if (w_alu_req) begin
      r_we <= 1'b1;
      r_wa <= alu_wa;
      r_wd <= alu_wd;
    end else if (w_sel_head) begin
      r_we <= !w_head_killed;
      if (!w_head_killed) begin
        r_wa <= r_q_wa[r_rd_ptr];
        r_wd <= r_q_wd[r_rd_ptr];
      end
    end else if (w_bypass) begin
      r_we <= 1'b1;
      r_wa <= lsu_wa;
      r_wd <= lsu_wd;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign we         = r_we;
  assign wa         = r_wa;
  assign wd         = r_wd;
  assign q_count    = r_count;
  assign raw_hazard = w_hazard;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter (QDEPTH = 4).
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_wa = '0;
  logic [31:0] alu_wd = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_wa = '0;
  logic [31:0] lsu_wd = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic        raw_hazard;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_fail   = 0;

  gpr_wb_arbiter #(.QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wa(lsu_wa), .lsu_wd(lsu_wd),
    .rs(rs), .rt(rt), .raw_hazard(raw_hazard),
    .we(we), .wa(wa), .wd(wd), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_wa = '0; lsu_wd = '0;
  endtask

  task automatic drive(input logic av, input logic [4:0] aw, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lw, input logic [31:0] ld);
    alu_valid = av; alu_wa = aw; alu_wd = ad;
    lsu_valid = lv; lsu_wa = lw; lsu_wd = ld;
  endtask

  task automatic check_wr(input string tag, input logic e_we, input logic [4:0] e_wa,
                          input logic [31:0] e_wd, input logic [2:0] e_cnt);
    check({tag, ".we"}, 32'(we), 32'(e_we));
    check({tag, ".wa"}, 32'(wa), 32'(e_wa));
    check({tag, ".wd"}, wd, e_wd);
    check({tag, ".cnt"}, 32'(q_count), 32'(e_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    logic [4:0] next_wa;

    // Reset state
    #12;
    check_wr("rst", 1'b0, 5'd0, 32'd0, 3'd0);
    check("rst.ready", 32'(lsu_ready), 32'd0);
    check("rst.haz", 32'(raw_hazard), 32'd0);
    rst = 1'b0;
    #1;
    check("rel.ready", 32'(lsu_ready), 32'd1);

    // Bypass
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF);
    tick();
    idle();
    check_wr("byp", 1'b1, 5'd7, 32'hDEADBEEF, 3'd0);
    tick();
    check_wr("byp.idle", 1'b0, 5'd7, 32'hDEADBEEF, 3'd0);

    // Priority and FIFO order
    drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2);
    tick();
    check_wr("pri0", 1'b1, 5'd3, 32'd1, 3'd1);
    drive(1'b1, 5'd5, 32'd3, 1'b1, 5'd6, 32'd4);
    tick();
    idle();
    check_wr("pri1", 1'b1, 5'd5, 32'd3, 3'd2);
    tick();
    check_wr("pri2", 1'b1, 5'd4, 32'd2, 3'd1);
    tick();
    check_wr("pri3", 1'b1, 5'd6, 32'd4, 3'd0);
    tick();
    check("pri.idle.we", 32'(we), 32'd0);

    // Full queue: ALU holds the port for 6 cycles while LSU pushes
    accepted = 0;
    next_wa  = 5'd2;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 5'd1, 32'(c), 1'b1, next_wa, 32'(next_wa) + 32'h100);
      #1;
      check($sformatf("full.ready%0d", c), 32'(lsu_ready), (c < 4) ? 32'd1 : 32'd0);
      if (lsu_ready) begin
        accepted++;
        next_wa = next_wa + 5'd1;
      end
      tick();
    end
    idle();
    check("full.accepted", 32'(accepted), 32'd4);
    check("full.cnt", 32'(q_count), 32'd4);
    #1;
    check("full.ready.drain", 32'(lsu_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_wr($sformatf("drain%0d", k), 1'b1, 5'(k + 2), 32'(k + 2) + 32'h100, 3'(3 - k));
    end
    tick();
    check("drain.idle.we", 32'(we), 32'd0);

    // Kill: queued wa=9 superseded by a younger ALU write
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
    tick();
    check_wr("kill0", 1'b1, 5'd1, 32'h11, 3'd1);
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
    rs = 5'd9;
    #1;
    check("kill.haz.before", 32'(raw_hazard), 32'd1);
    tick();
    idle();
    rs = 5'd0;
    check_wr("kill1", 1'b1, 5'd9, 32'h55, 3'd1);
    tick();
    check_wr("kill.pop", 1'b0, 5'd9, 32'h55, 3'd0);
    tick();
    check("kill.idle.we", 32'(we), 32'd0);

    // Hazard
    drive(1'b1, 5'd1, 32'd0, 1'b1, 5'd12, 32'hC);
    tick();
    drive(1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0);
    rs = 5'd12; rt = 5'd0;
    #1;
    check("haz.queued", 32'(raw_hazard), 32'd1);
    rs = 5'd0; rt = 5'd0;
    #1;
    check("haz.zero", 32'(raw_hazard), 32'd0);
    tick();
    idle();
    tick();
    check_wr("haz.issue", 1'b1, 5'd12, 32'hC, 3'd0);
    rt = 5'd12;
    #1;
    check("haz.output", 32'(raw_hazard), 32'd1);
    rt = 5'd13;
    #1;
    check("haz.nomatch", 32'(raw_hazard), 32'd0);
    rt = 5'd0;

    // Reset mid-operation with three entries queued
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd1, 32'h77, 1'b1, 5'(20 + k), 32'(k));
      tick();
    end
    idle();
    rs = 5'd20;
    check("mid.cnt", 32'(q_count), 32'd3);
    #1;
    check("mid.haz", 32'(raw_hazard), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_wr("mid.rst", 1'b0, 5'd0, 32'd0, 3'd0);
    check("mid.rst.ready", 32'(lsu_ready), 32'd0);
    check("mid.rst.haz", 32'(raw_hazard), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("mid.rel.ready", 32'(lsu_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("mid.post%0d.we", k), 32'(we), 32'd0);
      check($sformatf("mid.post%0d.cnt", k), 32'(q_count), 32'd0);
    end
    check("mid.post.haz", 32'(raw_hazard), 32'd0);
    rs = 5'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
